// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM state encoding,
// issue-select encoding and bus field widths.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned WE_W    = 4;
   localparam int unsigned IADDR_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_IWAIT = 2'd1,
      ST_DWAIT = 2'd2
   } state_e;

   // Which requester owns the bus in the current free cycle.
   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_PEND  = 2'd1,
      SEL_DATA  = 2'd2,
      SEL_FETCH = 2'd3
   } sel_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports and the shared memory bus, bundled for the arbiter.
// The arbiter uses the slave view; the core/memory environment uses master.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic [IADDR_W-1:0] imem_addr;
   logic               imem_oe;
   logic [DATA_W-1:0]  imem_rdata;
   logic               imem_valid;

   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_oe;
   logic [DATA_W-1:0]  mem_wdata;
   logic [WE_W-1:0]    mem_we;
   logic [DATA_W-1:0]  mem_rdata;
   logic               mem_valid;
   logic               mem_ready;

   logic [ADDR_W-1:0]  bus_addr;
   logic               bus_oe;
   logic [WE_W-1:0]    bus_we;
   logic [DATA_W-1:0]  bus_wdata;
   logic [DATA_W-1:0]  bus_rdata;
   logic               bus_rvalid;
   logic               bus_ready;

   modport slave (
      input  imem_addr, imem_oe, mem_addr, mem_oe, mem_wdata, mem_we,
             bus_rdata, bus_rvalid, bus_ready,
      output imem_rdata, imem_valid, mem_rdata, mem_valid, mem_ready,
             bus_addr, bus_oe, bus_we, bus_wdata
   );

   modport master (
      output imem_addr, imem_oe, mem_addr, mem_oe, mem_wdata, mem_we,
             bus_rdata, bus_rvalid, bus_ready,
      input  imem_rdata, imem_valid, mem_rdata, mem_valid, mem_ready,
             bus_addr, bus_oe, bus_we, bus_wdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access,
// one outstanding read at a time, with a one-deep pending-fetch slot.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter logic [ADDR_W-1:0] IMEM_BASE = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  io
);

   state_e              state_q, state_d;
   logic                pending_q, pending_d;
   logic                stale_q, stale_d;
   logic [IADDR_W-1:0]  pend_addr_q, pend_addr_d;
   sel_e                sel;
   logic                free;
   logic                xfer;
   logic [IADDR_W-1:0]  fetch_addr;

   // A read return frees the bus in the same cycle, so a new issue can overlap it.
   assign free = (state_q == ST_IDLE) || io.bus_rvalid;
   assign xfer = (sel != SEL_NONE) && io.bus_ready;

   always_comb begin
      sel = SEL_NONE;
      if (!rst && free) begin
         if (pending_q)       sel = SEL_PEND;
         else if (io.mem_oe)  sel = SEL_DATA;
         else if (io.imem_oe) sel = SEL_FETCH;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         stale_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         stale_q   <= stale_d;
      end
   end

   // NOTE: the pending address is qualified by pending_q, so it carries no reset.
   always_ff @(posedge clk) begin
      pend_addr_q <= pend_addr_d;
   end

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      stale_d     = stale_q;
      pend_addr_d = pend_addr_q;

      if (state_q != ST_IDLE && io.bus_rvalid) state_d = ST_IDLE;
      if (xfer) begin
         unique case (sel)
            SEL_PEND, SEL_FETCH: state_d = ST_IWAIT;
            SEL_DATA:            if (io.mem_we == '0) state_d = ST_DWAIT;
            default:             state_d = state_q;
         endcase
      end

      // A fetch that cannot go out now waits in the slot; a newer one replaces it.
      if (io.imem_oe && !(xfer && sel == SEL_FETCH)) begin
         pending_d   = 1'b1;
         pend_addr_d = io.imem_addr;
      end else if (xfer && sel == SEL_PEND) begin
         pending_d   = 1'b0;
      end

      if (state_q == ST_IWAIT && io.bus_rvalid)  stale_d = 1'b0;
      else if (state_q == ST_IWAIT && io.imem_oe) stale_d = 1'b1;
   end

   always_comb begin
      fetch_addr    = (sel == SEL_PEND) ? pend_addr_q : io.imem_addr;
      io.bus_oe     = (sel != SEL_NONE);
      io.bus_wdata  = io.mem_wdata;
      if (sel == SEL_DATA) begin
         io.bus_addr = io.mem_addr;
         io.bus_we   = io.mem_we;
      end else begin
         io.bus_addr = IMEM_BASE + {{(ADDR_W-IADDR_W){1'b0}}, fetch_addr};
         io.bus_we   = '0;
      end

      io.imem_rdata = io.bus_rdata;
      io.mem_rdata  = io.bus_rdata;
      io.imem_valid = !rst && state_q == ST_IWAIT && io.bus_rvalid && !stale_q;
      io.mem_valid  = !rst && state_q == ST_DWAIT && io.bus_rvalid;
      // Built only from registered state and bus inputs: the core loops mem_oe back on it.
      io.mem_ready  = !rst && free && io.bus_ready && !pending_q;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the processor's instruction-fetch port and its data port.
- Sits between the processor core and the unified memory/peripheral bus.
- Sequences one outstanding bus transaction at a time.
- Returns read data to the port that issued it, using the core's valid/ready semantics: accept on ready, data on valid one or more cycles later.

Parameters:
- IMEM_BASE, 32'h00000000, byte address added to the zero-extended 16-bit fetch address to form the bus address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- imem_addr  in  16  fetch byte address
- imem_oe  in  1  fetch request this cycle
- imem_rdata  out  32  fetch data
- imem_valid  out  1  fetch data valid (1-cycle pulse)
- mem_addr  in  32  data byte address
- mem_oe  in  1  data request this cycle
- mem_wdata  in  32  store data
- mem_we  in  4  byte write enables; 0 = read
- mem_rdata  out  32  load data
- mem_valid  out  1  load data valid (1-cycle pulse)
- mem_ready  out  1  data request can be accepted this cycle
- bus_addr  out  32  bus address
- bus_oe  out  1  bus request
- bus_we  out  4  bus byte enables; 0 = read
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_rvalid  in  1  bus read data valid
- bus_ready  in  1  bus accepts request this cycle

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE, pending flag is 0, stale flag is 0.
  - bus_oe=0, bus_we=0, imem_valid=0, mem_valid=0, mem_ready=0 while rst=1.
- Bus transfer rule:
  - A transfer occurs when bus_oe && bus_ready.
  - bus_oe must not depend on bus_ready.
  - bus_rvalid arrives no earlier than the cycle after a read is accepted.
- Reads and writes:
  - Writes are posted: no response, and the FSM stays in IDLE.
  - Reads move the FSM to IWAIT (fetch) or DWAIT (data).
- free = (state==IDLE) || bus_rvalid. Exactly one new transfer may be issued in a free cycle, including the cycle of a read return.
- Priority, highest first:
  - (1) registered pending fetch;
  - (2) data request (mem_oe);
  - (3) new fetch (imem_oe).
- mem_ready = !rst && free && bus_ready && !pending.
  - mem_ready must have no combinational path from mem_oe, mem_we, mem_addr or imem_oe; the core closes a loop through them.
- Fetch handling:
  - imem_oe in a cycle where it is not issued (not free, data wins, or bus_ready=0) sets pending and latches the address in pend_addr.
  - A new imem_oe overwrites pend_addr.
  - When the pending fetch is issued, pending clears.
- Read responses:
  - IWAIT + bus_rvalid: imem_valid=1 and imem_rdata=bus_rdata in the same cycle (combinational pass-through), unless stale.
  - DWAIT + bus_rvalid: mem_valid=1 and mem_rdata=bus_rdata in the same cycle.
  - The valid outputs are 0 otherwise; the rdata outputs are don't-care otherwise.
- Stale fetch:
  - imem_oe while in IWAIT (before bus_rvalid) sets stale.
  - The in-flight response is then dropped (imem_valid held 0), and the new fetch is queued as pending.
  - stale clears on that return.
- Address formation:
  - Fetch bus_addr = IMEM_BASE + {16'h0, addr}.
  - Data bus_addr = mem_addr.
  - bus_wdata = mem_wdata.
  - bus_we = mem_we for data transfers, 0 for fetches.
- FSM transitions:
  - IDLE -> IWAIT on fetch issue.
  - IDLE -> DWAIT on data-read issue.
  - IWAIT/DWAIT -> IDLE on bus_rvalid, or directly to IWAIT/DWAIT if a new read is issued that same cycle.
- Reset mid-transaction: return to IDLE, drop outstanding data, suppress any valid until after a new issue.

Decomposition:
- Shared package: state encodings (IDLE, IWAIT, DWAIT) and the bus-request field widths.
- No sub-module is needed. The priority select and address mux stay inline with the FSM.

Test Plan:
- Zero-wait bus, fetch at 0x0000 then 0x0004 on consecutive cycles -> bus reads 0x0, 0x4 back-to-back; imem_valid high the cycle after each, with data matching memory.
- imem_oe and a load to 0x100 in the same cycle -> load issued first; mem_valid next cycle; fetch pending and issued on the load-return cycle; imem_valid one cycle later; mem_ready=0 while pending.
- Store 0xDEADBEEF we=4'b1111 to 0x200 followed by a load of 0x200 -> store accepted with no mem_valid; load returns 0xDEADBEEF.
- bus_ready held low 3 cycles with a load pending -> mem_ready=0 for those cycles; no bus_oe transfer; the load completes after bus_ready rises.
- Fetch 0x0010 in flight with a 2-cycle read latency, new imem_oe 0x0040 the next cycle -> the 0x0010 response is suppressed; only the 0x0040 data produces imem_valid.
- rst asserted while in DWAIT -> next cycle IDLE; mem_valid stays 0 even when the late bus_rvalid arrives.
